// File: rtl/cluster_count_monitor.sv
// Windowed statistics over the per-cycle cluster count: total, peak and overflow-sample count,
// latched at each window end, plus an overflow burst detector and a sticky overflow flag.
module cluster_count_monitor #(
  parameter int unsigned CNT_BITS     = 11,
  parameter int unsigned SUM_BITS     = 32,
  parameter int unsigned OVF_BITS     = 24,
  parameter int unsigned WIN_BITS     = 24,
  parameter int unsigned BURST_THRESH = 4
) (
  input  logic                clock4x,
  input  logic                reset,
  input  logic                enable_i,
  input  logic                clear_i,
  input  logic [WIN_BITS-1:0] window_len_i,
  input  logic [CNT_BITS-1:0] cnt_i,
  input  logic                overflow_i,
  output logic [SUM_BITS-1:0] sum_o,
  output logic [CNT_BITS-1:0] max_o,
  output logic [OVF_BITS-1:0] ovf_cnt_o,
  output logic                done_o,
  output logic                busy_o,
  output logic                burst_o,
  output logic                sticky_ovf_o
);

  localparam int unsigned RunBits  = $clog2(BURST_THRESH + 1);
  localparam int unsigned WideBits = ((SUM_BITS > CNT_BITS) ? SUM_BITS : CNT_BITS) + 1;
  localparam logic [WideBits-1:0] SumMax  = WideBits'({SUM_BITS{1'b1}});
  localparam logic [RunBits-1:0]  RunSat  = RunBits'(BURST_THRESH);

  typedef enum logic {StIdle, StRun} state_e;

  state_e              state_q, state_d;
  logic [WIN_BITS-1:0] len_q, len_d;
  logic [WIN_BITS-1:0] idx_q, idx_d;
  logic [SUM_BITS-1:0] acc_sum_q, acc_sum_d;
  logic [CNT_BITS-1:0] acc_max_q, acc_max_d;
  logic [OVF_BITS-1:0] acc_ovf_q, acc_ovf_d;
  logic [SUM_BITS-1:0] sum_q, sum_d;
  logic [CNT_BITS-1:0] max_q, max_d;
  logic [OVF_BITS-1:0] ovf_cnt_q, ovf_cnt_d;
  logic                done_q, done_d;
  logic [RunBits-1:0]  run_q, run_d;
  logic                burst_q, burst_d;
  logic                sticky_q, sticky_d;

  // Accumulators with this cycle's sample folded in.
  logic [WideBits-1:0] sum_wide;
  logic [SUM_BITS-1:0] sum_next;
  logic [CNT_BITS-1:0] max_next;
  logic [OVF_BITS-1:0] ovf_next;
  logic                last_sample;

  always_comb begin
    sum_wide    = WideBits'(acc_sum_q) + WideBits'(cnt_i);
    sum_next    = (sum_wide > SumMax) ? {SUM_BITS{1'b1}} : sum_wide[SUM_BITS-1:0];
    max_next    = (cnt_i > acc_max_q) ? cnt_i : acc_max_q;
    ovf_next    = (overflow_i && (acc_ovf_q != {OVF_BITS{1'b1}})) ?
                  acc_ovf_q + OVF_BITS'(1) : acc_ovf_q;
    last_sample = (idx_q == len_q - WIN_BITS'(1));
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    acc_sum_d = acc_sum_q;
    acc_max_d = acc_max_q;
    acc_ovf_d = acc_ovf_q;
    sum_d     = sum_q;
    max_d     = max_q;
    ovf_cnt_d = ovf_cnt_q;
    done_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (enable_i && (window_len_i != '0)) begin
          state_d   = StRun;
          len_d     = window_len_i;
          idx_d     = '0;
          acc_sum_d = '0;
          acc_max_d = '0;
          acc_ovf_d = '0;
        end
      end
      StRun: begin
        if (!enable_i) begin
          // Abort: partial window discarded, latched results untouched.
          state_d   = StIdle;
          idx_d     = '0;
          acc_sum_d = '0;
          acc_max_d = '0;
          acc_ovf_d = '0;
        end else if (last_sample) begin
          sum_d     = sum_next;
          max_d     = max_next;
          ovf_cnt_d = ovf_next;
          done_d    = 1'b1;
          idx_d     = '0;
          acc_sum_d = '0;
          acc_max_d = '0;
          acc_ovf_d = '0;
          len_d     = window_len_i;
          if (window_len_i == '0) begin
            state_d = StIdle;
          end
        end else begin
          acc_sum_d = sum_next;
          acc_max_d = max_next;
          acc_ovf_d = ovf_next;
          idx_d     = idx_q + WIN_BITS'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Burst and sticky logic run regardless of the window FSM.
  always_comb begin
    if (!overflow_i) begin
      run_d = '0;
    end else if (run_q == RunSat) begin
      run_d = run_q;
    end else begin
      run_d = run_q + RunBits'(1);
    end
    burst_d  = (run_d == RunSat);
    sticky_d = overflow_i | (sticky_q & ~clear_i);
  end

  always_ff @(posedge clock4x) begin
    if (reset) begin
      state_q   <= StIdle;
      len_q     <= '0;
      idx_q     <= '0;
      acc_sum_q <= '0;
      acc_max_q <= '0;
      acc_ovf_q <= '0;
      sum_q     <= '0;
      max_q     <= '0;
      ovf_cnt_q <= '0;
      done_q    <= 1'b0;
      run_q     <= '0;
      burst_q   <= 1'b0;
      sticky_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      acc_sum_q <= acc_sum_d;
      acc_max_q <= acc_max_d;
      acc_ovf_q <= acc_ovf_d;
      sum_q     <= sum_d;
      max_q     <= max_d;
      ovf_cnt_q <= ovf_cnt_d;
      done_q    <= done_d;
      run_q     <= run_d;
      burst_q   <= burst_d;
      sticky_q  <= sticky_d;
    end
  end

  assign sum_o        = sum_q;
  assign max_o        = max_q;
  assign ovf_cnt_o    = ovf_cnt_q;
  assign done_o       = done_q;
  assign busy_o       = (state_q == StRun);
  assign burst_o      = burst_q;
  assign sticky_ovf_o = sticky_q;

endmodule

// File: tb/tb_cluster_count_monitor.sv
// Bench for cluster_count_monitor: directed scenarios then random traffic, two instances
// (32-bit and 8-bit sum) checked against a window-level reference model.
module tb_cluster_count_monitor;

  logic        clock4x = 1'b0;
  logic        reset, enable, clear, overflow;
  logic [23:0] window_len;
  logic [10:0] cnt;

  logic [31:0] sum;
  logic [7:0]  sum8;
  logic [10:0] max_a, max_b;
  logic [23:0] oc_a, oc_b;
  logic        done_a, done_b, busy_a, busy_b, burst_a, burst_b, sticky_a, sticky_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock4x = ~clock4x;

  cluster_count_monitor dut (
    .clock4x(clock4x), .reset(reset), .enable_i(enable), .clear_i(clear),
    .window_len_i(window_len), .cnt_i(cnt), .overflow_i(overflow),
    .sum_o(sum), .max_o(max_a), .ovf_cnt_o(oc_a), .done_o(done_a), .busy_o(busy_a),
    .burst_o(burst_a), .sticky_ovf_o(sticky_a)
  );

  cluster_count_monitor #(.SUM_BITS(8)) dut8 (
    .clock4x(clock4x), .reset(reset), .enable_i(enable), .clear_i(clear),
    .window_len_i(window_len), .cnt_i(cnt), .overflow_i(overflow),
    .sum_o(sum8), .max_o(max_b), .ovf_cnt_o(oc_b), .done_o(done_b), .busy_o(busy_b),
    .burst_o(burst_b), .sticky_ovf_o(sticky_b)
  );

  // Reference model: the open window is a list of samples; results are computed from it
  // whenever it reaches the captured length.
  bit     m_run;
  int     m_len;
  int     win_cnt[$];
  int     win_ovf[$];
  int     m_consec;
  longint e_sum;
  int     e_max, e_ovf;
  bit     e_done, e_burst, e_sticky;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    longint s;
    int     mx, no;
    if (reset) begin
      m_run = 0; m_len = 0; win_cnt.delete(); win_ovf.delete(); m_consec = 0;
      e_sum = 0; e_max = 0; e_ovf = 0; e_done = 0; e_burst = 0; e_sticky = 0;
      return;
    end
    m_consec = overflow ? m_consec + 1 : 0;
    e_burst  = (m_consec >= 4);
    e_sticky = overflow || (e_sticky && !clear);
    e_done   = 0;
    if (!m_run) begin
      if (enable && window_len != 0) begin
        m_run = 1; m_len = int'(window_len); win_cnt.delete(); win_ovf.delete();
      end
    end else if (!enable) begin
      m_run = 0; win_cnt.delete(); win_ovf.delete();
    end else begin
      win_cnt.push_back(int'(cnt));
      win_ovf.push_back(int'(overflow));
      if (win_cnt.size() == m_len) begin
        s = 0; mx = 0; no = 0;
        foreach (win_cnt[i]) begin
          s += win_cnt[i];
          if (win_cnt[i] > mx) mx = win_cnt[i];
          no += win_ovf[i];
        end
        e_sum = s; e_max = mx; e_ovf = no; e_done = 1;
        win_cnt.delete(); win_ovf.delete();
        m_len = int'(window_len);
        if (window_len == 0) m_run = 0;
      end
    end
  endtask

  task automatic compare_all();
    longint s32, s8;
    s32 = (e_sum > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : e_sum;
    s8  = (e_sum > 255) ? 255 : e_sum;
    check("sum",    64'(sum),      64'(s32));
    check("sum8",   64'(sum8),     64'(s8));
    check("max",    64'(max_a),    64'(e_max));
    check("max8",   64'(max_b),    64'(e_max));
    check("ovf",    64'(oc_a),     64'(e_ovf));
    check("ovf8",   64'(oc_b),     64'(e_ovf));
    check("done",   64'(done_a),   64'(e_done));
    check("done8",  64'(done_b),   64'(e_done));
    check("busy",   64'(busy_a),   64'(m_run));
    check("busy8",  64'(busy_b),   64'(m_run));
    check("burst",  64'(burst_a),  64'(e_burst));
    check("sticky", 64'(sticky_a), 64'(e_sticky));
    check("sticky8", 64'(sticky_b), 64'(e_sticky));
  endtask

  task automatic drive(input bit r, input bit en, input bit cl, input int wl, input int c,
                       input bit ov);
    reset = r; enable = en; clear = cl; window_len = 24'(wl); cnt = 11'(c); overflow = ov;
  endtask

  task automatic step();
    @(posedge clock4x);
    model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    bit prev_ovf;
    drive(1, 0, 0, 0, 0, 0);
    step();
    step();
    check("rst_sum_zero", 64'(sum), 64'd0);

    // 1: len=4, cnt 1..4
    drive(0, 1, 0, 4, 77, 0);
    step();
    for (int i = 1; i <= 4; i++) begin
      drive(0, 1, 0, 4, i, 0);
      step();
    end
    check("t1_done", 64'(done_a), 64'd1);
    check("t1_sum", 64'(sum), 64'd10);
    check("t1_max", 64'(max_a), 64'd4);
    drive(0, 0, 0, 4, 0, 0);
    step();

    // 2: overflow runs of 3 and 5, then clear
    for (int i = 0; i < 3; i++) begin drive(0, 0, 0, 0, 0, 1); step(); end
    check("t2_no_burst", 64'(burst_a), 64'd0);
    drive(0, 0, 0, 0, 0, 0); step();
    for (int i = 0; i < 5; i++) begin drive(0, 0, 0, 0, 0, 1); step(); end
    check("t2_burst", 64'(burst_a), 64'd1);
    drive(0, 0, 0, 0, 0, 0); step();
    check("t2_burst_drop", 64'(burst_a), 64'd0);
    check("t2_sticky", 64'(sticky_a), 64'd1);
    drive(0, 0, 1, 0, 0, 0); step();
    check("t2_cleared", 64'(sticky_a), 64'd0);

    // 3: saturation of the 8-bit instance
    drive(0, 1, 0, 3, 0, 0); step();
    for (int i = 0; i < 3; i++) begin drive(0, 1, 0, 3, 100, 0); step(); end
    check("t3_sum8_sat", 64'(sum8), 64'd255);
    check("t3_max8", 64'(max_b), 64'd100);
    drive(0, 0, 0, 0, 0, 0); step();

    // 4: abort after 3 of 8 samples, then a fresh window
    drive(0, 1, 0, 8, 0, 0); step();
    for (int i = 0; i < 3; i++) begin drive(0, 1, 0, 8, 500 + i, 0); step(); end
    drive(0, 0, 0, 8, 9, 0); step();
    check("t4_abort_busy", 64'(busy_a), 64'd0);
    check("t4_hold_sum", 64'(sum), 64'd300);
    for (int i = 0; i < 10; i++) begin drive(0, 1, 0, 8, 20 + i, 0); step(); end
    drive(0, 0, 0, 0, 0, 0); step();

    // 5: back-to-back windows of 2
    drive(0, 1, 0, 2, 0, 0); step();
    for (int i = 5; i <= 8; i++) begin
      drive(0, 1, 0, 2, i, 0);
      step();
      if (i == 6) check("t5_sum_a", 64'(sum), 64'd11);
    end
    check("t5_sum_b", 64'(sum), 64'd15);
    check("t5_max_b", 64'(max_a), 64'd8);

    // 6: clear vs overflow, then reset mid-window
    drive(0, 1, 1, 2, 3, 1); step();
    check("t6_sticky_kept", 64'(sticky_a), 64'd1);
    drive(0, 1, 0, 2, 3, 0); step();
    drive(1, 1, 0, 2, 3, 0); step();
    check("t6_reset_busy", 64'(busy_a), 64'd0);

    // Random traffic
    prev_ovf = 0;
    for (int n = 0; n < 4000; n++) begin
      bit r, en, cl, ov;
      int wl;
      r  = ($urandom_range(0, 499) == 0);
      en = ($urandom_range(0, 19) != 0);
      cl = ($urandom_range(0, 9) == 0);
      wl = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 6));
      ov = prev_ovf ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 7) == 0);
      prev_ovf = ov;
      drive(r, en, cl, wl, int'($urandom_range(0, 2047)), ov);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
